// File: rtl/hp_rd_arbiter.sv
// Round-robin share of one HP read port (AR/R) among N_REQ readers; single ID keeps R in grant order.
// Latency: AR 1 cycle (requester handshake t -> m_arvalid t+1), R path 0 cycles.
// Backpressure: no AR grant while ISSUE or MAX_OUTST bursts in flight; m_rready follows the owning requester's rready.
module hp_rd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 8
) (
  input  logic                        fclk,
  input  logic                        fclk_rst_n,
  input  logic [N_REQ-1:0]            req_arvalid,
  output logic [N_REQ-1:0]            req_arready,
  input  logic [N_REQ*ADDR_W-1:0]     req_araddr,
  input  logic [N_REQ*4-1:0]          req_arlen,
  output logic [N_REQ-1:0]            req_rvalid,
  input  logic [N_REQ-1:0]            req_rready,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [1:0]                  req_rresp,
  output logic                        req_rlast,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [3:0]                  m_arlen,
  output logic [5:0]                  m_arid,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt,
  output logic                        err_unexp
);
  localparam int GW = $clog2(N_REQ);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [3:0]          arlen_q, arlen_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]       fifo_q [MAX_OUTST];
  logic [GW-1:0]       fifo_d [MAX_OUTST];

  logic                gnt_vld;
  logic [GW-1:0]       gnt_idx;
  logic                can_grant;
  logic                empty;
  logic [GW-1:0]       head;
  logic                push;
  logic                pop;

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && req_arvalid[(int'(ptr_q) + k) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign can_grant   = (state_q == IDLE) && gnt_vld && (cnt_q < CW'(MAX_OUTST));
  assign req_arready = can_grant ? (N_REQ'(1) << gnt_idx) : '0;

  assign empty      = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign req_rvalid = (m_rvalid && !empty) ? (N_REQ'(1) << head) : '0;
  assign m_rready   = !empty && req_rready[head];
  assign req_rdata  = m_rdata;
  assign req_rresp  = m_rresp;
  assign req_rlast  = m_rlast;

  assign push = (state_q == ISSUE) && m_arready;
  assign pop  = m_rvalid && m_rready && m_rlast;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fifo_d   = fifo_q;
    err_d    = err_q | (m_rvalid & empty);

    case (state_q)
      IDLE: begin
        if (can_grant) begin
          araddr_d = req_araddr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          arlen_d  = req_arlen[int'(gnt_idx)*4 +: 4];
          gnt_d    = gnt_idx;
          ptr_d    = (gnt_idx == GW'(N_REQ-1)) ? '0 : gnt_idx + GW'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (m_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = gnt_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // A same-cycle push and pop leave the in-flight count alone.
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge fclk or negedge fclk_rst_n) begin
    if (!fclk_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q   <= fifo_d;
    end
  end

  assign m_arvalid = (state_q == ISSUE);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arid    = '0;
  assign m_arsize  = 3'($clog2(DATA_W/8));
  assign m_arburst = 2'b01;
  assign outst_cnt = cnt_q;
  assign err_unexp = err_q;

endmodule

// File: doc/hp_rd_arbiter.md
# hp_rd_arbiter

Round-robin read arbiter that shares one PS7 high-performance slave port read channel (s_axi_hp_N, AR/R only) among N_REQ fabric read masters. It issues each granted burst on the HP port with a single fixed ID, which keeps responses in order. It records the grant order in an in-flight FIFO and routes returning R beats to the owning requester. It sits in the shell between user DMA readers and the ps_7 HP port.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, HP port data width (32 or 64)
- MAX_OUTST, 8, maximum bursts in flight (power of two, 2..16)
- fclk  in  1  clock; all logic is in this single clock domain
- fclk_rst_n  in  1  asynchronous active-low reset
- req_arvalid  in  N_REQ  per-requester read address valid
- req_arready  out  N_REQ  per-requester read address ready
- req_araddr  in  N_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_arlen  in  N_REQ*4  packed AXI3 burst lengths (beats-1)
- req_rvalid  out  N_REQ  per-requester read data valid
- req_rready  in  N_REQ  per-requester read data ready
- req_rdata  out  DATA_W  shared read data
- req_rresp  out  2  shared read response
- req_rlast  out  1  shared last beat
- m_arvalid / m_arready  out / in  1 / 1  HP port AR handshake
- m_araddr  out  ADDR_W  HP port address
- m_arlen  out  4  HP port burst length
- m_arid  out  6  constant 0
- m_arsize  out  3  constant log2(DATA_W/8)
- m_arburst  out  2  constant 2'b01 (INCR)
- m_rvalid / m_rready  in / out  1 / 1  HP port R handshake
- m_rdata, m_rresp, m_rlast  in  DATA_W, 2, 1  HP port R payload
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of bursts in flight
- err_unexp  out  1  sticky flag: R beat arrived with no burst in flight

## Operation
- AR state machine, two states:
  - IDLE: if any req_arvalid and outst_cnt < MAX_OUTST:
    - pick grant g round-robin, starting from ptr;
    - assert req_arready[g] in this cycle (combinational);
    - register araddr/arlen of requester g into m_araddr/m_arlen and g into gnt_q;
    - set ptr = (g+1) mod N_REQ;
    - go to ISSUE.
  - ISSUE: m_arvalid=1 with a stable payload. On m_arready: push gnt_q into the in-flight FIFO, increment outst_cnt, go to IDLE.
- req_arready is never high in ISSUE. At most one requester's req_arready is high in any cycle.
- In-flight FIFO: depth MAX_OUTST, width $clog2(N_REQ). Head h is the owner of the current R burst.
- R routing (combinational, zero latency), with e = FIFO empty:
  - req_rvalid[h] = m_rvalid & !e; all other req_rvalid bits are 0.
  - m_rready = req_rready[h] & !e.
  - req_rdata, req_rresp and req_rlast mirror the m_ signals.
- Pop FIFO and decrement outst_cnt on m_rvalid & m_rready & m_rlast.
- Simultaneous AR push and R-last pop: outst_cnt is unchanged; FIFO pointers advance independently.
- m_rvalid while e: m_rready stays 0 (beat is not consumed) and err_unexp is set. err_unexp clears only on reset.
- rresp is passed through unmodified. The block does not count beats and relies on rlast.

## Timing
- Reset values:
  - state=IDLE, ptr=0, m_arvalid=0, m_araddr=0, m_arlen=0;
  - FIFO empty, outst_cnt=0, err_unexp=0;
  - req_arready=0, req_rvalid=0, m_rready=0.
- AR latency: requester handshake in cycle t → m_arvalid high from t+1. Best-case throughput is one AR every 2 cycles.
- Full condition: when outst_cnt == MAX_OUTST, req_arready stays 0 until the cycle after the rlast pop.
- R path latency: 0 cycles. Full throughput of 1 beat/cycle when req_rready[h] is held high.
- Reset asserted mid-operation: all state clears immediately. In-flight bursts are forgotten; the PS port and requesters must be reset together.
- AXI rules: m_araddr/m_arlen must not change while m_arvalid=1 and m_arready=0. A requester may drop req_arvalid only after its handshake.

## Test plan
- Single request: requester 2 issues addr 0x1000_0000, len 3; m_arready=1 → m_arvalid in the next cycle with that payload. Then 4 R beats with rlast on beat 4 → only req_rvalid[2] toggles; outst_cnt goes 1→0.
- Contention: all 4 requesters hold arvalid from reset → grant order 0,1,2,3,0. Then only requesters 1 and 3 active → grant order 1,3,1,3.
- Full stall: MAX_OUTST=8, m_rvalid=0, 10 requests → 8 issued, outst_cnt=8, req_arready held 0. One burst completes → 9th request is granted the cycle after the pop.
- Routing with backpressure: bursts issued to requesters 0 then 3 (len 1 each); req_rready[0] toggled → data for requester 0 is fully delivered before requester 3 sees any rvalid; m_rready follows req_rready[0].
- Simultaneous push/pop: m_arready handshake in the same cycle as an rlast pop → outst_cnt is unchanged and FIFO order is preserved.
- Unexpected beat: m_rvalid=1 with FIFO empty → m_rready=0, err_unexp=1, sticky until fclk_rst_n pulse. Reset asserted while in ISSUE → m_arvalid=0 and outst_cnt=0 immediately.
